// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// the helper that classifies which operations advance the frame counter.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  // Shifts and rotates are the operations that move one bit through the frame.
  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage : univ_shift_pkg

// File: rtl/shift_frame_counter.sv
// Counts completed shifts/rotates modulo WIDTH and emits a registered
// one-cycle pulse on the edge that completes a full WIDTH-bit frame.
module shift_frame_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic inc,
  input  logic clr,
  output logic frame_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  // Count register with explicit wrap at WIDTH-1 (WIDTH need not be a power of two).
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      frame_done <= 1'b0;
    end else if (en) begin
      frame_done <= inc && (count == LAST);
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        count <= (count == LAST) ? '0 : count + CW'(1);
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule : shift_frame_counter

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, shift/rotate left/right, parallel load
// and clear, with serial taps at both ends and a full-frame pulse.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             frame_done
);

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_next;
  logic             shift_op;
  logic             clr_op;

  assign mode_sel = mode_e'(mode);
  assign shift_op = is_shift(mode_sel);
  assign clr_op   = (mode_sel == MODE_LOAD) || (mode_sel == MODE_CLEAR);

  // Mode mux: next register value for the selected operation.
  // NOTE: q_next gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    q_next = q;
    unique case (mode_sel)
      MODE_SHL:   q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR:   q_next = {sin_l, q[WIDTH-1:1]};
      MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      MODE_LOAD:  q_next = d;
      MODE_CLEAR: q_next = RESET_VAL;
      MODE_HOLD,
      MODE_RSVD:  q_next = q;
      default:    q_next = q;
    endcase
  end

  // Storage register: updates only when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= q_next;
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  shift_frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .inc        (shift_op),
    .clr        (clr_op),
    .frame_done (frame_done)
  );

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): directed
// scenarios followed by randomized operations against a behavioural model.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic [W-1:0] d = '0;
  logic         sin_l = 1'b0;
  logic         sin_r = 1'b0;
  logic [W-1:0] q;
  logic         sout_l;
  logic         sout_r;
  logic         frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: register value, shifts since last frame boundary, pulse.
  logic [W-1:0] m_q   = '0;
  int           m_cnt = 0;
  logic         m_fd  = 1'b0;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .d          (d),
    .sin_l      (sin_l),
    .sin_r      (sin_r),
    .q          (q),
    .sout_l     (sout_l),
    .sout_r     (sout_r),
    .frame_done (frame_done)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model of one clock edge, written from the operation definitions with arithmetic.
  task automatic model_edge(input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                            input logic sl, input logic sr);
    int v;
    v = int'(m_q);
    m_fd = 1'b0;
    if (!e) return;
    case (m)
      3'd1: v = ((v * 2) % 256) + int'(sr);
      3'd2: v = (v / 2) + 128 * int'(sl);
      3'd3: v = ((v * 2) % 256) + (v / 128);
      3'd4: v = (v / 2) + 128 * (v % 2);
      3'd5: v = int'(dd);
      3'd6: v = 0;
      default: ;
    endcase
    m_q = v[W-1:0];
    if (m >= 3'd1 && m <= 3'd4) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == W) begin
        m_cnt = 0;
        m_fd  = 1'b1;
      end
    end else if (m == 3'd5 || m == 3'd6) begin
      m_cnt = 0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " q"}, 32'(q), 32'(m_q));
    check({tag, " sout_l"}, 32'(sout_l), 32'(m_q[W-1]));
    check({tag, " sout_r"}, 32'(sout_r), 32'(m_q[0]));
    check({tag, " frame_done"}, 32'(frame_done), 32'(m_fd));
  endtask

  // Drive one operation, let one edge pass, sample 1 time unit later.
  task automatic step(input string tag, input logic e, input logic [2:0] m,
                      input logic [W-1:0] dd, input logic sl, input logic sr);
    en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    @(posedge clk);
    #1;
    model_edge(e, m, dd, sl, sr);
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed between edges; effect checked before the next edge.
  task automatic pulse_reset(input string tag);
    #10;
    reset = 1'b1;
    #5;
    m_q = '0; m_cnt = 0; m_fd = 1'b0;
    check({tag, " q"}, 32'(q), 32'h00);
    check({tag, " frame_done"}, 32'(frame_done), 32'h0);
    #5;
    reset = 1'b0;
  endtask

  initial begin
    // 1. Power-on reset, then asynchronous reset mid-cycle.
    #100;
    reset = 1'b0;
    check("por q", 32'(q), 32'h00);
    check("por frame_done", 32'(frame_done), 32'h0);
    step("load 5A", 1'b1, 3'd5, 8'h5A, 1'b0, 1'b0);
    check("load 5A const", 32'(q), 32'h5A);
    pulse_reset("async reset");

    // 2. Parallel load and enable gating.
    step("load A5", 1'b1, 3'd5, 8'hA5, 1'b0, 1'b0);
    check("A5 q", 32'(q), 32'hA5);
    check("A5 sout_l", 32'(sout_l), 32'h1);
    check("A5 sout_r", 32'(sout_r), 32'h1);
    step("en0 load FF", 1'b0, 3'd5, 8'hFF, 1'b0, 1'b0);
    check("en0 hold", 32'(q), 32'hA5);

    // 3. Single shifts and hold codes.
    step("shl", 1'b1, 3'd1, 8'h00, 1'b0, 1'b1);
    check("shl const", 32'(q), 32'h4B);
    step("reload A5", 1'b1, 3'd5, 8'hA5, 1'b0, 1'b0);
    step("shr", 1'b1, 3'd2, 8'h00, 1'b0, 1'b1);
    check("shr const", 32'(q), 32'h52);
    step("hold 000", 1'b1, 3'd0, 8'hFF, 1'b1, 1'b1);
    check("hold const", 32'(q), 32'h52);
    step("hold 111", 1'b1, 3'd7, 8'hFF, 1'b1, 1'b1);
    check("rsvd const", 32'(q), 32'h52);

    // 4. Full-frame rotates.
    step("load 81", 1'b1, 3'd5, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      step("rol", 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
      check("rol pulse", 32'(frame_done), 32'(i == W - 1));
    end
    check("rol x8 q", 32'(q), 32'h81);
    step("after rol", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
    check("rol pulse width", 32'(frame_done), 32'h0);
    for (int i = 0; i < W; i++) begin
      step("ror", 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
      check("ror pulse", 32'(frame_done), 32'(i == W - 1));
    end
    check("ror x8 q", 32'(q), 32'h81);

    // 5. Frame straddling HOLD cycles.
    step("load C3", 1'b1, 3'd5, 8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 5) step("straddle hold", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
      else                  step("straddle shl", 1'b1, 3'd1, 8'h00, 1'b0, i[0]);
      check("straddle pulse", 32'(frame_done), 32'(i == 9));
    end

    // 6. LOAD discards a partial frame; so does reset.
    step("load 3C", 1'b1, 3'd5, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("partial shr", 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
    step("reload 3C", 1'b1, 3'd5, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      step("frame shr", 1'b1, 3'd2, 8'h00, i[0], 1'b0);
      check("load discard pulse", 32'(frame_done), 32'(i == W - 1));
    end
    for (int i = 0; i < 5; i++) step("partial shr2", 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
    pulse_reset("reset mid-frame");
    for (int i = 0; i < W; i++) begin
      step("post-reset shr", 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
      check("reset discard pulse", 32'(frame_done), 32'(i == W - 1));
    end
    // Reset while the pulse is high clears it without a clock edge.
    for (int i = 0; i < W; i++) step("to pulse", 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    check("pulse high before reset", 32'(frame_done), 32'h1);
    pulse_reset("reset kills pulse");

    // Randomized operations, biased toward shifts so frames complete often.
    for (int i = 0; i < 400; i++) begin
      logic       e;
      logic [2:0] m;
      e = ($urandom_range(0, 7) != 0);
      m = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) pulse_reset("rand reset");
      else step("rand", e, m, 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_univ_shift_reg
